// File: rtl/rst_pkg.sv
// Shared types and constants for the staged reset sequencer and its cause register.
// Holds the FSM state encoding, the cause bit layout and a small sizing helper.
// No logic here, so there is no latency or backpressure.
package rst_pkg;

    typedef enum logic [1:0] {
        ASSERT  = 2'd0,
        HOLD    = 2'd1,
        RELEASE = 2'd2,
        RUN     = 2'd3
    } rst_seq_state_e;

    localparam int unsigned RstCauseW    = 3;
    localparam int unsigned RstCausePor  = 0;
    localparam int unsigned RstCauseNdm  = 1;
    localparam int unsigned RstCauseUart = 2;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rst_cause_reg.sv
// Sticky reset-cause register: por on power-on reset, ndm/uart OR-ed in on capture.
// Updates one edge after capture/clear are sampled.
// No backpressure; a clear on a capture edge keeps only the freshly captured bits.
module rst_cause_reg
    import rst_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 capture_i,
    input  logic                 ndm_i,
    input  logic                 uart_i,
    input  logic                 clr_i,
    output logic [RstCauseW-1:0] cause_o
);

    localparam logic [RstCauseW-1:0] PorOnly = RstCauseW'(1 << RstCausePor);

    logic [RstCauseW-1:0] capt_dat;

    always_comb begin
        capt_dat               = '0;
        capt_dat[RstCauseNdm]  = ndm_i;
        capt_dat[RstCauseUart] = uart_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cause_o <= PorOnly;
        end else if (clr_i) begin
            cause_o <= capture_i ? capt_dat : '0;
        end else if (capture_i) begin
            cause_o <= cause_o | capt_dat;
        end
    end

endmodule

// File: rtl/rst_seq.sv
// Staged reset sequencer: releases domains 0..N-1 in order after a hold, one per gap.
// Domain k releases HoldCycles + k*GapCycles edges after the request clears; all outputs registered.
// No backpressure; a new request on any edge aborts the sequence and restarts from domain 0.
module rst_seq
    import rst_pkg::*;
#(
    parameter int unsigned NumDomains = 4,
    parameter int unsigned HoldCycles = 16,
    parameter int unsigned GapCycles  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  sys_rst_ni,
    input  logic                  ndmreset_i,
    input  logic                  prog_uart_i,
    input  logic                  clr_cause_i,
    output logic [NumDomains-1:0] dom_rst_no,
    output logic                  done_o,
    output logic [RstCauseW-1:0]  rst_cause_o,
    output logic [1:0]            state_o
);

    localparam int unsigned CntW = $clog2(max_u(HoldCycles, GapCycles) + 1);
    localparam int unsigned IdxW = (NumDomains > 1) ? $clog2(NumDomains) : 1;

    localparam logic [CntW-1:0] HoldLast = CntW'(HoldCycles - 1);
    localparam logic [CntW-1:0] GapLast  = CntW'(GapCycles - 1);
    localparam logic [IdxW-1:0] IdxLast  = IdxW'(NumDomains - 1);

    rst_seq_state_e        state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [NumDomains-1:0] dom_q, dom_d;
    logic                  done_q, done_d;
    logic                  capture;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ASSERT;
            cnt_q   <= '0;
            idx_q   <= '0;
            dom_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            dom_q   <= dom_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        dom_d   = dom_q;
        done_d  = done_q;
        capture = 1'b0;

        unique case (state_q)
            ASSERT: begin
                if (sys_rst_ni) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end
            end
            HOLD: begin
                if (cnt_q == HoldLast) begin
                    dom_d[0] = 1'b1;
                    cnt_d    = '0;
                    if (NumDomains == 1) begin
                        state_d = RUN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RELEASE;
                        idx_d   = IdxW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            RELEASE: begin
                if (cnt_q == GapLast) begin
                    for (int k = 0; k < NumDomains; k++) begin
                        if (IdxW'(k) == idx_q) begin
                            dom_d[k] = 1'b1;
                        end
                    end
                    cnt_d = '0;
                    if (idx_q == IdxLast) begin
                        state_d = RUN;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            RUN: begin
            end
            default: state_d = ASSERT;
        endcase

        // A fresh request overrides whatever progress was made; capture only on entry.
        if (state_q != ASSERT && !sys_rst_ni) begin
            state_d = ASSERT;
            cnt_d   = '0;
            idx_d   = '0;
            dom_d   = '0;
            done_d  = 1'b0;
            capture = 1'b1;
        end
    end

    rst_cause_reg u_cause (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .capture_i (capture),
        .ndm_i     (ndmreset_i),
        .uart_i    (prog_uart_i),
        .clr_i     (clr_cause_i),
        .cause_o   (rst_cause_o)
    );

    assign dom_rst_no = dom_q;
    assign done_o     = done_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_rst_seq.sv
// Bench for rst_seq: default instance plus a 1/1/1 corner instance on shared stimulus.
// Checks every cycle against a release-time model and pins key points with literals.
module tb_rst_seq;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       sys_rst_ni;
    logic       ndmreset_i;
    logic       prog_uart_i;
    logic       clr_cause_i;

    logic [3:0] dom_a;
    logic       done_a;
    logic [2:0] cause_a;
    logic [1:0] state_a;

    logic [0:0] dom_b;
    logic       done_b;
    logic [2:0] cause_b;
    logic [1:0] state_b;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    rst_seq #(.NumDomains(4), .HoldCycles(16), .GapCycles(4)) u_dut_a (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .sys_rst_ni  (sys_rst_ni),
        .ndmreset_i  (ndmreset_i),
        .prog_uart_i (prog_uart_i),
        .clr_cause_i (clr_cause_i),
        .dom_rst_no  (dom_a),
        .done_o      (done_a),
        .rst_cause_o (cause_a),
        .state_o     (state_a)
    );

    rst_seq #(.NumDomains(1), .HoldCycles(1), .GapCycles(1)) u_dut_b (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .sys_rst_ni  (sys_rst_ni),
        .ndmreset_i  (ndmreset_i),
        .prog_uart_i (prog_uart_i),
        .clr_cause_i (clr_cause_i),
        .dom_rst_no  (dom_b),
        .done_o      (done_b),
        .rst_cause_o (cause_b),
        .state_o     (state_b)
    );

    // Model: t = edges since the request cleared (E0 -> 0), -1 while held in reset.
    int         t       = -1;
    logic [2:0] mcause  = 3'b001;
    bit         started = 1'b0;

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            t      = -1;
            mcause = 3'b001;
        end else begin
            bit cap;
            cap = (t >= 0) && !sys_rst_ni;
            if (clr_cause_i)
                mcause = cap ? {prog_uart_i, ndmreset_i, 1'b0} : 3'b000;
            else if (cap)
                mcause = mcause | {prog_uart_i, ndmreset_i, 1'b0};
            if (t < 0)
                t = sys_rst_ni ? 0 : -1;
            else if (!sys_rst_ni)
                t = -1;
            else if (t < 1000)
                t = t + 1;
        end
        started = 1'b1;
    end

    function automatic logic [31:0] exp_dom(int tt, int n, int h, int g);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < n; k++)
            if (tt >= 0 && tt >= h + k * g) r[k] = 1'b1;
        return r;
    endfunction

    function automatic logic [31:0] exp_state(int tt, int n, int h, int g);
        if (tt < 0)                 return 32'd0;
        if (tt < h)                 return 32'd1;
        if (tt < h + (n - 1) * g)   return 32'd2;
        return 32'd3;
    endfunction

    function automatic logic [31:0] exp_done(int tt, int n, int h, int g);
        return (tt >= 0 && tt >= h + (n - 1) * g) ? 32'd1 : 32'd0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0d, time %0t)", name, act, exp, t, $time);
        end
    endtask

    always @(negedge clk_i) begin
        if (started) begin
            check("a_dom",   32'(dom_a),   exp_dom(t, 4, 16, 4));
            check("a_done",  32'(done_a),  exp_done(t, 4, 16, 4));
            check("a_state", 32'(state_a), exp_state(t, 4, 16, 4));
            check("a_cause", 32'(cause_a), 32'(mcause));
            check("b_dom",   32'(dom_b),   exp_dom(t, 1, 1, 1));
            check("b_done",  32'(done_b),  exp_done(t, 1, 1, 1));
            check("b_state", 32'(state_b), exp_state(t, 1, 1, 1));
            check("b_cause", 32'(cause_b), 32'(mcause));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #2;
    endtask

    // Leaves the caller 2ns after E0.
    task automatic restart();
        sys_rst_ni = 1'b0;
        tick(1);
        sys_rst_ni = 1'b1;
        tick(1);
    endtask

    initial begin
        rst_i       = 1'b1;
        sys_rst_ni  = 1'b1;
        ndmreset_i  = 1'b0;
        prog_uart_i = 1'b0;
        clr_cause_i = 1'b0;
        tick(3);
        check("por_dom",   32'(dom_a),   32'h0);
        check("por_cause", 32'(cause_a), 32'h1);
        rst_i = 1'b0;

        // Power-on sequence with defaults.
        tick(1);
        check("t1_b_e0p1_pre", 32'(state_b), 32'd1);
        check("t1_a_e0",       32'(state_a), 32'd1);
        tick(1);
        check("t1_b_dom_e0p1",   32'(dom_b),   32'h1);
        check("t1_b_done_e0p1",  32'(done_b),  32'h1);
        check("t1_b_state_e0p1", 32'(state_b), 32'd3);
        tick(14);
        check("t1_dom_e0p15", 32'(dom_a), 32'h0);
        tick(1);
        check("t1_dom_e0p16", 32'(dom_a), 32'h1);
        tick(4);
        check("t1_dom_e0p20", 32'(dom_a), 32'h3);
        tick(4);
        check("t1_dom_e0p24", 32'(dom_a), 32'h7);
        check("t1_done_e0p24", 32'(done_a), 32'h0);
        tick(4);
        check("t1_dom_e0p28",  32'(dom_a),   32'hf);
        check("t1_done_e0p28", 32'(done_a),  32'h1);
        check("t1_cause",      32'(cause_a), 32'h1);

        // Mid-release request with ndmreset.
        restart();
        tick(21);
        check("t2_dom_e0p21", 32'(dom_a), 32'h3);
        sys_rst_ni = 1'b0;
        ndmreset_i = 1'b1;
        tick(1);
        check("t2_dom_abort",   32'(dom_a),   32'h0);
        check("t2_done_abort",  32'(done_a),  32'h0);
        check("t2_state_abort", 32'(state_a), 32'd0);
        check("t2_cause",       32'(cause_a), 32'h3);
        sys_rst_ni = 1'b1;
        ndmreset_i = 1'b0;
        tick(1);
        tick(15);
        check("t2_dom_e0p15", 32'(dom_a), 32'h0);
        tick(1);
        check("t2_dom_e0p16", 32'(dom_a), 32'h1);
        tick(12);
        check("t2_dom_e0p28", 32'(dom_a), 32'hf);

        // Asynchronous power-on reset in the middle of HOLD.
        restart();
        tick(5);
        check("t5_state_hold", 32'(state_a), 32'd1);
        rst_i = 1'b1;
        #1;
        check("t5_dom_async",   32'(dom_a),   32'h0);
        check("t5_state_async", 32'(state_a), 32'd0);
        check("t5_b_dom_async", 32'(dom_b),   32'h0);
        check("t5_b_done_async", 32'(done_b), 32'h0);
        check("t5_cause_async", 32'(cause_a), 32'h1);
        tick(1);
        rst_i = 1'b0;
        tick(1);
        tick(28);
        check("t5_dom_run", 32'(dom_a), 32'hf);

        // Request held for 50 cycles in RUN with UART mode.
        sys_rst_ni  = 1'b0;
        prog_uart_i = 1'b1;
        tick(1);
        check("t3_cause_entry", 32'(cause_a), 32'h5);
        tick(10);
        ndmreset_i = 1'b1;
        tick(39);
        check("t3_dom_held",   32'(dom_a),   32'h0);
        check("t3_state_held", 32'(state_a), 32'd0);
        check("t3_cause_held", 32'(cause_a), 32'h5);
        sys_rst_ni  = 1'b1;
        prog_uart_i = 1'b0;
        ndmreset_i  = 1'b0;
        tick(1);
        tick(28);
        check("t3_dom_restart", 32'(dom_a), 32'hf);

        // Clear coinciding with capture.
        rst_i = 1'b1;
        tick(1);
        rst_i = 1'b0;
        tick(1);
        tick(28);
        check("t4_cause_pre", 32'(cause_a), 32'h1);
        sys_rst_ni  = 1'b0;
        ndmreset_i  = 1'b1;
        clr_cause_i = 1'b1;
        tick(1);
        check("t4_cause_clrcap", 32'(cause_a), 32'h2);
        check("t4_state",        32'(state_a), 32'd0);
        clr_cause_i = 1'b0;
        ndmreset_i  = 1'b0;
        sys_rst_ni  = 1'b1;
        tick(1);
        clr_cause_i = 1'b1;
        tick(1);
        clr_cause_i = 1'b0;
        check("t4_cause_clr", 32'(cause_a), 32'h0);
        tick(30);
        check("t4_dom_end", 32'(dom_a), 32'hf);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
